byte_word_packer: RTL and testbench

- Downstream stage for the 8-bit registered data path.
- Consumes one byte per cycle from the upstream register stage and packs 4 consecutive bytes little-endian into 32-bit words.
- Buffers packed words in a small FIFO and presents them on a valid/ready interface to the bus-side consumer.
- Upstream has no backpressure, so FIFO exhaustion is reported through a sticky overflow flag.

---
 rtl/byte_word_packer_if.sv | 35 +++
 rtl/byte_word_packer.sv | 114 +++++++++++
 tb/tb_byte_word_packer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out bundle for byte_word_packer.
//   in_valid, in_data : one byte per cycle from upstream, no backpressure
//   flush             : push whatever partial word is held
//   out_valid, out_data, out_keep, out_ready : word output stream
//   level, overflow   : FIFO occupancy and sticky drop flag
// Handshake: a word transfers at a posedge where out_valid && out_ready are
// both 1. While out_valid=1 and out_ready=0, out_data/out_keep hold steady.
// out_ready has no effect while out_valid=0. The input side has no ready; a
// byte is taken at every posedge where in_valid=1.
interface byte_word_packer_if #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          flush;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;

    // Environment side: produces bytes and consumes words.
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, out_keep, level, overflow
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, out_keep, level, overflow
    );
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs consecutive bytes little-endian into 32-bit words
// and queues them in a DEPTH-entry FIFO with no fall-through.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-low reset
//   bus   : byte_word_packer_if.slave (byte input, word output, status)
module byte_word_packer #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    byte_word_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Packer state: next lane index and the lanes 0..2 written so far.
    logic [1:0]  idx;
    logic [23:0] pack;

    // FIFO state; pointers carry one extra bit so full and empty differ.
    logic [35:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        overflow_q;

    logic [31:0]   asm_word;
    logic [2:0]    held;
    logic [3:0]    push_keep;
    logic          push_word;
    logic          do_push;
    logic          pop;
    logic          full;
    logic [LW-1:0] level_w;
    logic [35:0]   head;

    // Word as it would look after including this cycle's byte.
    always_comb begin
        asm_word = {8'h00, pack};
        if (bus.in_valid) begin
            case (idx)
                2'd0:    asm_word[7:0]   = bus.in_data;
                2'd1:    asm_word[15:8]  = bus.in_data;
                2'd2:    asm_word[23:16] = bus.in_data;
                default: asm_word[31:24] = bus.in_data;
            endcase
        end
    end

    // Bytes held counting a same-cycle byte; sets both keep and flush push.
    assign held = {1'b0, idx} + {2'b00, bus.in_valid};

    always_comb begin
        case (held)
            3'd1:    push_keep = 4'b0001;
            3'd2:    push_keep = 4'b0011;
            3'd3:    push_keep = 4'b0111;
            3'd4:    push_keep = 4'b1111;
            default: push_keep = 4'b0000;
        endcase
    end

    // A lane-3 byte with flush is still a single push.
    assign push_word = (bus.in_valid && (idx == 2'd3)) ||
                       (bus.flush && (held != 3'd0));

    assign level_w = wr_ptr - rd_ptr;
    assign full    = (level_w == LW'(DEPTH));
    assign pop     = (level_w != '0) && bus.out_ready;
    // A slot freed by a same-edge pop can be refilled at that edge.
    assign do_push = push_word && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= 2'd0;
            pack       <= 24'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            // The packer restarts even when the word is dropped.
            if (push_word) begin
                idx  <= 2'd0;
                pack <= 24'h0;
            end else if (bus.in_valid) begin
                idx  <= idx + 2'd1;
                pack <= asm_word[23:0];
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_word && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= {push_keep, asm_word};
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.out_valid = (level_w != '0);
    assign bus.out_data  = bus.out_valid ? head[31:0]  : 32'h0;
    assign bus.out_keep  = bus.out_valid ? head[35:32] : 4'h0;
    assign bus.level     = level_w;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  byte_word_packer_if #(.DEPTH(DEPTH)) bus ();

  byte_word_packer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // driver tasks: inputs change 1 time unit after posedge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic f);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.flush    = f;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom_range(0, 255));
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h5A;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%08h exp=00000000", bus.out_data); end
    checks++; if (bus.out_keep !== 4'h0) begin errors++; $display("FAIL reset_out_keep got=%0h exp=0", bus.out_keep); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0h exp=0", bus.overflow); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    bus.out_ready = 1'b1;
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL word_early got=%0h exp=0", bus.out_valid); end
    drive_byte(8'h44, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL word_valid got=%0h exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h44332211) begin errors++; $display("FAIL word_data got=%08h exp=44332211", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL word_keep got=%0h exp=f", bus.out_keep); end
    checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL word_level got=%0d exp=1", bus.level); end
    tick();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL word_pop_level got=%0d exp=0", bus.level); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL word_pop_valid got=%0h exp=0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_byte(8'(i), 1'b0);
    for (int w = 0; w < 4; w++) exp_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", bus.level); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0h exp=1", bus.overflow); end
    checks++; if (bus.out_data !== 32'h03020100) begin errors++; $display("FAIL ovf_stable got=%08h exp=03020100", bus.out_data); end
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++; if (bus.out_data !== exp_w || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain got=%08h v=%0h exp=%08h", bus.out_data, bus.out_valid, exp_w); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0h exp=1", bus.overflow); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL flush_noop got=%0d exp=0", bus.level); end
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL flush_level got=%0d exp=1", bus.level); end
    checks++; if (bus.out_data !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data got=%08h exp=0000bbaa", bus.out_data); end
    checks++; if (bus.out_keep !== 4'b0011) begin errors++; $display("FAIL flush_keep got=%0h exp=3", bus.out_keep); end
    drive_byte(8'hCC, 1'b1);
    checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL flush2_level got=%0d exp=2", bus.level); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_data !== 32'h000000CC) begin errors++; $display("FAIL flush2_data got=%08h exp=000000cc", bus.out_data); end
    checks++; if (bus.out_keep !== 4'b0001) begin errors++; $display("FAIL flush2_keep got=%0h exp=1", bus.out_keep); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL flush_drain got=%0d exp=0", bus.level); end
  endtask

  task automatic test_flush_lane3();
    bus.out_ready = 1'b0;
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h03, 1'b0);
    drive_byte(8'h04, 1'b1);
    checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL l3flush_level got=%0d exp=1", bus.level); end
    checks++; if (bus.out_data !== 32'h04030201) begin errors++; $display("FAIL l3flush_data got=%08h exp=04030201", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL l3flush_keep got=%0h exp=f", bus.out_keep); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL l3flush_drain got=%0d exp=0", bus.level); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_byte(8'(8'h20 + i), 1'b0);
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL b2b_fill got=%0d exp=4", bus.level); end
    drive_byte(8'h30, 1'b0);
    drive_byte(8'h31, 1'b0);
    drive_byte(8'h32, 1'b0);
    bus.out_ready = 1'b1;
    drive_byte(8'h33, 1'b0);
    exp_q = '{32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C, 32'h33323130};
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL b2b_level got=%0d exp=4", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%0h exp=0", bus.overflow); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++; if (bus.out_data !== exp_w || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_drain got=%08h v=%0h exp=%08h", bus.out_data, bus.out_valid, exp_w); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0h exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_byte(8'(8'h40 + i), 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive_byte(8'h54, 1'b0);
    drive_byte(8'h55, 1'b0);
    checks++; if (bus.level !== 3'd3 || bus.overflow !== 1'b1) begin errors++; $display("FAIL arst_pre level=%0d ovf=%0h exp=3,1", bus.level, bus.overflow); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%0h exp=0", bus.out_valid); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL arst_level got=%0d exp=0", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got=%0h exp=0", bus.overflow); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL arst_data got=%08h exp=00000000", bus.out_data); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    drive_byte(8'h61, 1'b0);
    drive_byte(8'h62, 1'b0);
    drive_byte(8'h63, 1'b0);
    drive_byte(8'h64, 1'b0);
    checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL arst_post_level got=%0d exp=1", bus.level); end
    checks++; if (bus.out_data !== 32'h64636261) begin errors++; $display("FAIL arst_post_data got=%08h exp=64636261", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL arst_post_keep got=%0h exp=f", bus.out_keep); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_overflow();
    test_flush();
    test_flush_lane3();
    test_back_to_back();
    test_async_reset();
    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
